// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between a 5-stage pipeline datapath and its hazard controller.
// The pipeline side drives decode/EX/MEM status; the controller returns stage enables and bubbles.
interface pipeline_hazard_ctrl_if;
  // Data-memory handshake: mem_req is held high for every cycle a load/store
  // occupies MEM and has not completed; the access completes on the first
  // cycle where mem_req and mem_ack are both high, and mem_req may drop after that.
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic       id_jump;
  logic       ex_memread;
  logic [4:0] ex_rt;
  logic       mem_branch_taken;
  logic       mem_access;
  logic       mem_ack;

  logic       pc_write;
  logic       ifid_write;
  logic       ifid_flush;
  logic       idex_bubble;
  logic       exmem_bubble;
  logic       pipe_hold;
  logic       mem_req;

  modport master (
    output id_rs, id_rt, id_uses_rt, id_jump, ex_memread, ex_rt,
           mem_branch_taken, mem_access, mem_ack,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, exmem_bubble,
           pipe_hold, mem_req
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, id_jump, ex_memread, ex_rt,
           mem_branch_taken, mem_access, mem_ack,
    output pc_write, ifid_write, ifid_flush, idex_bubble, exmem_bubble,
           pipe_hold, mem_req
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller: memory-wait hold with timeout, branch/jump flush, load-use stall,
// plus saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipeline_hazard_ctrl_if.slave hz,
    output logic                 err,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt,
    output logic [1:0]           dbg_state
);

    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);

    typedef enum logic [1:0] {
        RUN       = 2'b00,
        MEMW      = 2'b01,
        ERR       = 2'b10,
        ERR_ALIAS = 2'b11
    } state_t;

    state_t            state_q, state_nxt;
    logic [WAIT_W-1:0] wait_q, wait_nxt;
    logic              err_q, err_set;

    logic load_use;
    logic pc_write_c, ifid_write_c, ifid_flush_c;
    logic idex_bubble_c, exmem_bubble_c, pipe_hold_c, mem_req_c;
    logic eval_pipe;

    // Only a real load into a non-zero register can create a RAW hazard on the next instruction.
    assign load_use = hz.ex_memread && (hz.ex_rt != 5'd0) &&
                      ((hz.ex_rt == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));

    always_comb begin
        state_nxt      = state_q;
        wait_nxt       = wait_q;
        err_set        = 1'b0;
        eval_pipe      = 1'b0;
        pc_write_c     = 1'b0;
        ifid_write_c   = 1'b0;
        ifid_flush_c   = 1'b0;
        idex_bubble_c  = 1'b0;
        exmem_bubble_c = 1'b0;
        pipe_hold_c    = 1'b0;
        mem_req_c      = 1'b0;

        case (state_q)
            RUN: begin
                if (hz.mem_access) begin
                    mem_req_c = 1'b1;
                    if (!hz.mem_ack) begin
                        pipe_hold_c = 1'b1;
                        state_nxt   = MEMW;
                        wait_nxt    = WAIT_ONE;
                    end else begin
                        eval_pipe = 1'b1;
                    end
                end else begin
                    eval_pipe = 1'b1;
                end
            end
            MEMW: begin
                mem_req_c = 1'b1;
                if (hz.mem_ack) begin
                    // A late ack, even on the timeout cycle, releases the pipeline normally.
                    eval_pipe = 1'b1;
                    state_nxt = RUN;
                    wait_nxt  = '0;
                end else if (wait_q == WAIT_LIMIT) begin
                    pipe_hold_c = 1'b1;
                    state_nxt   = ERR;
                    err_set     = 1'b1;
                end else begin
                    pipe_hold_c = 1'b1;
                    wait_nxt    = wait_q + WAIT_ONE;
                end
            end
            default: begin
                // ERR and the unused encoding both freeze the machine until reset.
                pipe_hold_c = 1'b1;
                state_nxt   = ERR;
                err_set     = 1'b1;
            end
        endcase

        if (eval_pipe) begin
            if (hz.mem_branch_taken) begin
                pc_write_c     = 1'b1;
                ifid_write_c   = 1'b1;
                ifid_flush_c   = 1'b1;
                idex_bubble_c  = 1'b1;
                exmem_bubble_c = 1'b1;
            end else if (hz.id_jump) begin
                pc_write_c   = 1'b1;
                ifid_write_c = 1'b1;
                ifid_flush_c = 1'b1;
            end else if (load_use) begin
                idex_bubble_c = 1'b1;
            end else begin
                pc_write_c   = 1'b1;
                ifid_write_c = 1'b1;
            end
        end

        // Outputs are forced low for the whole time reset is asserted, independent of clk.
        if (!rst_n) begin
            pc_write_c     = 1'b0;
            ifid_write_c   = 1'b0;
            ifid_flush_c   = 1'b0;
            idex_bubble_c  = 1'b0;
            exmem_bubble_c = 1'b0;
            pipe_hold_c    = 1'b0;
            mem_req_c      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            wait_q  <= wait_nxt;
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_write_c && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (ifid_flush_c && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    assign hz.pc_write     = pc_write_c;
    assign hz.ifid_write   = ifid_write_c;
    assign hz.ifid_flush   = ifid_flush_c;
    assign hz.idex_bubble  = idex_bubble_c;
    assign hz.exmem_bubble = exmem_bubble_c;
    assign hz.pipe_hold    = pipe_hold_c;
    assign hz.mem_req      = mem_req_c;

    assign err       = err_q | state_q[1];
    assign dbg_state = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl with a small timeout and narrow counters.
module tb_pipeline_hazard_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;
  localparam int CMAX    = (1 << CNT_W) - 1;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if hz ();
  logic             err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [1:0]       dbg_state;

  pipeline_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hz        (hz.slave),
    .err       (err),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt),
    .dbg_state (dbg_state)
  );

  int vectors     = 0;
  int miscompares = 0;

  // reference model: waiting cycle count (0 = not waiting), error flag, counters
  int m_wait;
  bit m_err;
  int m_stall;
  int m_flush;
  logic [7:0] exp_q[$];

  // {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_bubble, pipe_hold, mem_req, err}
  function automatic logic [7:0] model_ctrl();
    bit waiting, lu, req;
    if (!rst_n) return 8'h00;
    if (m_err) return 8'b0000_0101;
    waiting = (m_wait > 0);
    if ((waiting || hz.mem_access) && !hz.mem_ack) return 8'b0000_0110;
    req = waiting || hz.mem_access;
    lu = hz.ex_memread && (hz.ex_rt != 0) &&
         (hz.ex_rt == hz.id_rs || (hz.id_uses_rt && hz.ex_rt == hz.id_rt));
    if (hz.mem_branch_taken) return {5'b11111, 1'b0, req, 1'b0};
    if (hz.id_jump)          return {5'b11100, 1'b0, req, 1'b0};
    if (lu)                  return {5'b00010, 1'b0, req, 1'b0};
    return {5'b11000, 1'b0, req, 1'b0};
  endfunction

  function automatic logic [1:0] model_state();
    if (m_err) return 2'd2;
    if (m_wait > 0) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [7:0] got_ctrl();
    return {hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.idex_bubble,
            hz.exmem_bubble, hz.pipe_hold, hz.mem_req, err};
  endfunction

  task automatic model_reset();
    m_wait = 0; m_err = 0; m_stall = 0; m_flush = 0;
  endtask

  // advance the model across one rising edge using the inputs present now
  task automatic model_clock();
    logic [7:0] e;
    e = model_ctrl();
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (!e[7] && m_stall < CMAX) m_stall++;
    if (e[5] && m_flush < CMAX) m_flush++;
    if (m_err) return;
    if (m_wait > 0) begin
      if (hz.mem_ack) m_wait = 0;
      else if (m_wait == TIMEOUT) begin m_err = 1; m_wait = 0; end
      else m_wait++;
    end else if (hz.mem_access && !hz.mem_ack) begin
      m_wait = 1;
    end
  endtask

  // driver tasks
  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                       input logic jump, input logic memread, input logic [4:0] ext,
                       input logic br, input logic acc, input logic ack);
    hz.id_rs = rs; hz.id_rt = rt; hz.id_uses_rt = uses_rt; hz.id_jump = jump;
    hz.ex_memread = memread; hz.ex_rt = ext; hz.mem_branch_taken = br;
    hz.mem_access = acc; hz.mem_ack = ack;
  endtask

  task automatic drive_idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drive_random();
    drive(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
          1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 1)));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    drive_idle();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic advance();
    model_clock();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      drive_random();
      @(negedge clk);
      vectors++;
      if ({got_ctrl(), stall_cnt, flush_cnt, dbg_state} !== 18'd0) begin
        miscompares++;
        $display("FAIL reset_outputs: got ctrl=%b stall=%0d flush=%0d state=%0d, want all 0",
                 got_ctrl(), stall_cnt, flush_cnt, dbg_state);
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
  endtask

  task automatic test_load_use();
    do_reset();
    drive(5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    vectors++;
    if ({hz.pc_write, hz.ifid_write, hz.idex_bubble} !== 3'b001 || got_ctrl() !== model_ctrl()) begin
      miscompares++;
      $display("FAIL load_use_stall: got ctrl=%b, want %b", got_ctrl(), model_ctrl());
    end
    advance();
    drive_idle();
    @(negedge clk);
    vectors++;
    if (stall_cnt !== 4'd1 || hz.pc_write !== 1'b1) begin
      miscompares++;
      $display("FAIL load_use_count: got stall_cnt=%0d pc_write=%b, want 1 and 1", stall_cnt, hz.pc_write);
    end
    advance();
  endtask

  task automatic test_gating();
    do_reset();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    vectors++;
    if (got_ctrl() !== 8'b1100_0000) begin
      miscompares++;
      $display("FAIL zero_reg_gate: got ctrl=%b, want 11000000", got_ctrl());
    end
    advance();
    drive(5'd3, 5'd7, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    vectors++;
    if (got_ctrl() !== 8'b1100_0000) begin
      miscompares++;
      $display("FAIL rt_unused_gate: got ctrl=%b, want 11000000", got_ctrl());
    end
    advance();
    drive(5'd3, 5'd7, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    vectors++;
    if (got_ctrl() !== 8'b0001_0000) begin
      miscompares++;
      $display("FAIL rt_used_stall: got ctrl=%b, want 00010000", got_ctrl());
    end
    advance();
  endtask

  task automatic test_priority();
    do_reset();
    drive(5'd9, 5'd0, 1'b0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    vectors++;
    if (got_ctrl() !== 8'b1111_1000) begin
      miscompares++;
      $display("FAIL priority_branch: got ctrl=%b, want 11111000", got_ctrl());
    end
    advance();
    drive(5'd9, 5'd0, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    vectors++;
    if (flush_cnt !== 4'd1 || got_ctrl() !== 8'b1110_0000) begin
      miscompares++;
      $display("FAIL priority_jump: got flush_cnt=%0d ctrl=%b, want 1 and 11100000", flush_cnt, got_ctrl());
    end
    advance();
  endtask

  task automatic test_mem_wait();
    int holds, reqs;
    holds = 0; reqs = 0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i < 3)       drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      else if (i == 3) drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
      else             drive_idle();
      @(negedge clk);
      holds += int'(hz.pipe_hold);
      reqs  += int'(hz.mem_req);
      vectors++;
      if ({got_ctrl(), stall_cnt, flush_cnt, dbg_state} !==
          {model_ctrl(), CNT_W'(m_stall), CNT_W'(m_flush), model_state()}) begin
        miscompares++;
        $display("FAIL mem_wait_cycle%0d: got ctrl=%b state=%0d, want ctrl=%b state=%0d",
                 i, got_ctrl(), dbg_state, model_ctrl(), model_state());
      end
      advance();
    end
    vectors++;
    if (holds !== 3 || reqs !== 4 || dbg_state !== 2'd0) begin
      miscompares++;
      $display("FAIL mem_wait_totals: got hold=%0d req=%0d state=%0d, want 3 4 0", holds, reqs, dbg_state);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (err !== 1'b0 || got_ctrl() !== model_ctrl()) begin
        miscompares++;
        $display("FAIL timeout_wait%0d: got err=%b ctrl=%b, want 0 and %b", i, err, got_ctrl(), model_ctrl());
      end
      advance();
    end
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (got_ctrl() !== 8'b0000_0101 || dbg_state !== 2'd2 || stall_cnt !== CNT_W'(m_stall)) begin
        miscompares++;
        $display("FAIL timeout_err_hold: got ctrl=%b state=%0d stall=%0d, want 00000101 2 %0d",
                 got_ctrl(), dbg_state, stall_cnt, m_stall);
      end
      advance();
    end
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    vectors++;
    if ({got_ctrl(), stall_cnt, flush_cnt, dbg_state} !== 18'd0) begin
      miscompares++;
      $display("FAIL timeout_async_reset: got ctrl=%b stall=%0d state=%0d, want all 0",
               got_ctrl(), stall_cnt, dbg_state);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive_idle();
    @(negedge clk);
    vectors++;
    if (got_ctrl() !== 8'b1100_0000 || dbg_state !== 2'd0) begin
      miscompares++;
      $display("FAIL timeout_recover: got ctrl=%b state=%0d, want 11000000 0", got_ctrl(), dbg_state);
    end
    advance();
  endtask

  task automatic test_saturation();
    do_reset();
    drive(5'd4, 5'd0, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vectors++;
      if (stall_cnt !== CNT_W'(m_stall) || hz.pc_write !== 1'b0) begin
        miscompares++;
        $display("FAIL sat_cycle%0d: got stall=%0d pc_write=%b, want %0d 0", i, stall_cnt, hz.pc_write, m_stall);
      end
      advance();
    end
    drive_idle();
    @(negedge clk);
    vectors++;
    if (stall_cnt !== 4'd15) begin
      miscompares++;
      $display("FAIL sat_final: got stall_cnt=%0d, want 15", stall_cnt);
    end
    advance();
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive_random();
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        model_reset();
      end else begin
        rst_n = 1'b1;
      end
      exp_q.push_back(model_ctrl());
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if ({got_ctrl(), stall_cnt, flush_cnt, dbg_state} !==
          {e, CNT_W'(m_stall), CNT_W'(m_flush), model_state()}) begin
        miscompares++;
        $display("FAIL random_cycle%0d: got ctrl=%b stall=%0d flush=%0d state=%0d, want %b %0d %0d %0d",
                 i, got_ctrl(), stall_cnt, flush_cnt, dbg_state, e, m_stall, m_flush, model_state());
      end
      advance();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_load_use();
    test_gating();
    test_priority();
    test_mem_wait();
    test_timeout();
    test_saturation();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL use a single clock and an asynchronous active-low reset: clk input, rst_n input.
REQ-002 The block SHALL provide these parameters (name, default, meaning):
- TIMEOUT, 255: maximum MEMW wait cycles.
- CNT_W, 16: width of the performance counters.
REQ-003 The block SHALL provide these ports (name, direction, width, meaning):
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- id_rs  in  5  ID-stage source register rs.
- id_rt  in  5  ID-stage source register rt.
- id_uses_rt  in  1  ID instruction reads rt (R-format, BEQ, SW).
- id_jump  in  1  J decoded in ID.
- ex_memread  in  1  EX-stage instruction is a load.
- ex_rt  in  5  EX-stage load destination.
- mem_branch_taken  in  1  BEQ resolved taken in MEM.
- mem_access  in  1  MEM stage holds a load or store.
- mem_ack  in  1  data memory completes the access this cycle.
- pc_write  out  1  PC register enable.
- ifid_write  out  1  IF/ID enable.
- ifid_flush  out  1  IF/ID zeroed next edge.
- idex_bubble  out  1  ID/EX control fields (WB, M, EX, J) forced to 0.
- exmem_bubble  out  1  EX/MEM control fields forced to 0.
- pipe_hold  out  1  freeze ID/EX, EX/MEM, MEM/WB.
- mem_req  out  1  data memory request.
- err  out  1  sticky memory-timeout flag.
- stall_cnt  out  CNT_W  cycles with pc_write=0.
- flush_cnt  out  CNT_W  cycles with ifid_flush=1.

Function
REQ-004 The block SHALL implement three states: RUN (00), MEMW (01), ERR (10); encoding 11 SHALL be treated as ERR.
REQ-005 All control outputs SHALL be combinational from state and inputs; the state, wait_cnt, err and the counters SHALL be registered.
REQ-006 In RUN, priority SHALL be: memory wait > branch > jump > load-use > normal.
REQ-007 RUN, mem_access=1, mem_ack=0: mem_req=1, pipe_hold=1, pc_write=0, ifid_write=0, flush/bubble=0; next state MEMW; wait_cnt<=1.
REQ-008 RUN, mem_access=1, mem_ack=1: mem_req=1, no hold; the remaining rules SHALL be evaluated in the same cycle.
REQ-009 Branch, mem_branch_taken=1: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1, exmem_bubble=1.
REQ-010 Jump, id_jump=1: pc_write=1, ifid_write=1, ifid_flush=1, other bubbles=0.
REQ-011 Load-use, when ex_memread=1, ex_rt!=0 and (ex_rt==id_rs or (id_uses_rt and ex_rt==id_rt)): pc_write=0, ifid_write=0, idex_bubble=1.
REQ-012 Normal: pc_write=1, ifid_write=1; all other control outputs 0.
REQ-013 MEMW, mem_ack=0: mem_req=1, pipe_hold=1, pc_write=0, ifid_write=0; wait_cnt increments.
- When wait_cnt==TIMEOUT: next state ERR and err<=1.
REQ-014 MEMW, mem_ack=1: mem_req=1, pipe_hold=0; REQ-009..012 SHALL be evaluated in the same cycle; next state RUN; wait_cnt<=0.
REQ-015 An ack on the TIMEOUT cycle SHALL win: return to RUN, err unchanged.
REQ-016 ERR: pipe_hold=1, pc_write=0, ifid_write=0, mem_req=0, err=1; ERR SHALL exit only on reset.
REQ-017 stall_cnt SHALL increment on every cycle with pc_write=0 and saturate at all-ones; flush_cnt likewise for ifid_flush=1.

Reset
REQ-018 While rst_n=0, the block SHALL hold state=RUN, wait_cnt=0, err=0, stall_cnt=0, flush_cnt=0, and drive every control output 0 (including pc_write and ifid_write), regardless of clk.
REQ-019 Reset asserted in MEMW or ERR SHALL take effect immediately; the first edge after deassertion SHALL operate in RUN.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Load-use: ex_memread=1, ex_rt=5, id_rs=5 -> one cycle with pc_write=0, idex_bubble=1; stall_cnt=1.
- $0 and rt gating: ex_rt=0, id_rs=0 -> no stall; ex_rt=7, id_rt=7, id_uses_rt=0 -> no stall.
- Priority: mem_branch_taken=1, id_jump=1 and a load-use all in one cycle -> flush+bubbles, pc_write=1, flush_cnt+1.
- Memory wait: mem_access=1, mem_ack low 3 cycles then high -> pipe_hold=1 for 3 cycles, mem_req high 4 cycles, back to RUN.
- Timeout: TIMEOUT=4, ack never -> err=1 after the 4th MEMW cycle, ERR holds; rst_n pulse clears everything.
- Saturation: CNT_W=4, 20 stall cycles -> stall_cnt=15.
